// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake on both sides.
// Define LOGIC_FLAGS_EN to add registered z_flag/n_flag outputs alongside Rz.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_FLAGS_EN
  output logic             z_flag,
  output logic             n_flag,
`endif
  output logic [WIDTH-1:0] Rz
);

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpXor  = 3'b010,
    OpNor  = 3'b011,
    OpNand = 3'b100,
    OpXnor = 3'b101,
    OpNot  = 3'b110,
    OpPass = 3'b111
  } op_e;

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_e              op_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] rz_q;
  logic [WIDTH-1:0] res;
  logic             adv1;
  logic             adv2;

  // A stage may load when it is empty or its contents leave on the same edge.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    res = '0;
    unique case (op_q)
      OpAnd:  res = a_q & b_q;
      OpOr:   res = a_q | b_q;
      OpXor:  res = a_q ^ b_q;
      OpNor:  res = ~(a_q | b_q);
      OpNand: res = ~(a_q & b_q);
      OpXnor: res = ~(a_q ^ b_q);
      OpNot:  res = ~a_q;
      OpPass: res = a_q;
      default: res = '0;
    endcase
  end

`ifdef LOGIC_FLAGS_EN
  logic z_q;
  logic n_q;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rz_q       <= '0;
`ifdef LOGIC_FLAGS_EN
      z_q        <= 1'b0;
      n_q        <= 1'b0;
`endif
    end else begin
      if (adv1) s1_valid_q <= in_valid;
      if (adv1 && in_valid) begin
        a_q  <= Ra;
        b_q  <= Rb;
        op_q <= op_e'(op);
      end
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) begin
        rz_q <= res;
`ifdef LOGIC_FLAGS_EN
        z_q  <= ~|res;
        n_q  <= res[WIDTH-1];
`endif
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign Rz        = rz_q;
`ifdef LOGIC_FLAGS_EN
  assign z_flag    = z_q;
  assign n_flag    = n_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=32 main instance, WIDTH=8 side instance).
// Flag checks are active when LOGIC_FLAGS_EN is defined.
module tb_logic_unit_pipe;

  localparam logic [2:0] AND = 3'd0, OR = 3'd1, XOR = 3'd2, NOR = 3'd3;
  localparam logic [2:0] NAND = 3'd4, XNOR = 3'd5, NOT = 3'd6, PASS = 3'd7;

  logic        clk = 1'b0;
  logic        clr, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] ra, rb, rz;
  logic        in_valid8, in_ready8, out_valid8;
  logic [2:0]  op8;
  logic [7:0]  ra8, rb8, rz8;
`ifdef LOGIC_FLAGS_EN
  logic        z_flag, n_flag, z8, n8;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .Ra(ra), .Rb(rb), .out_valid(out_valid), .out_ready(out_ready),
`ifdef LOGIC_FLAGS_EN
    .z_flag(z_flag), .n_flag(n_flag),
`endif
    .Rz(rz)
  );

  logic_unit_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .Ra(ra8), .Rb(rb8), .out_valid(out_valid8), .out_ready(1'b1),
`ifdef LOGIC_FLAGS_EN
    .z_flag(z8), .n_flag(n8),
`endif
    .Rz(rz8)
  );

  typedef struct {
    logic [31:0] rz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          lat_chk  = 1'b0;
  bit          last_acc = 1'b0;
  logic [31:0] nxt_exp;
  logic [31:0] held;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    case (o)
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOR:     return ~(a | b);
      NAND:    return ~(a & b);
      XNOR:    return ~(a ^ b);
      NOT:     return ~a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    in_valid = v;
    op       = o;
    ra       = a;
    rb       = b;
    nxt_exp  = exp;
  endtask

  // Observe handshakes mid-cycle, then advance to just after the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (clr) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() > 0) n_pass++;
        else $error("FAIL unexpected_result: observed %h expected no output", rz);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rz", rz, e.rz);
`ifdef LOGIC_FLAGS_EN
          check("z_flag", {31'b0, z_flag}, {31'b0, e.rz == 32'h0});
          check("n_flag", {31'b0, n_flag}, {31'b0, e.rz[31]});
`endif
          if (lat_chk) check("latency", cyc - e.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        e.rz  = nxt_exp;
        e.cyc = cyc;
        sb.push_back(e);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    in_valid8 = 1'b0; op8 = XOR; ra8 = 8'hA5; rb8 = 8'hFF;
    out_ready = 1'b1;
    clr       = 1'b1;
    // A request offered during reset must not be accepted.
    drive(1'b1, OR, 32'h1234_5678, 32'h0, 32'h1234_5678);
    cycle();
    cycle();
    clr = 1'b0;
    drive(1'b0, AND, 32'h0, 32'h0, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_rz", rz, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
`ifdef LOGIC_FLAGS_EN
    check("reset_z_flag", {31'b0, z_flag}, 32'h0);
`endif
    cycle();
    cycle();
    check("idle_out_valid", {31'b0, out_valid}, 32'h0);

    // Back-to-back ORs, fixed latency.
    lat_chk = 1'b1;
    drive(1'b1, OR, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
    cycle();
    drive(1'b1, OR, 32'h8888_8888, 32'h0000_0001, 32'h8888_8889);
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();

    // All eight ops on one operand pair.
    begin
      logic [31:0] sweep [8];
      sweep = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F,
                32'h0FFF_0FFF, 32'hF00F_F00F, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, sweep[i]);
        cycle();
      end
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("sweep_drained", sb.size(), 0);

    // Backpressure: two accepts fill the pipe, third request waits.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, AND, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608);
    cycle();
    drive(1'b1, XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
    cycle();
    drive(1'b1, NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    check("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
    check("bp_out_valid", {31'b0, out_valid}, 32'h1);
    held = rz;
    check("bp_rz_first", held, 32'h0204_0608);
    repeat (3) cycle();
    check("bp_rz_hold", rz, held);
    check("bp_in_ready_still_low", {31'b0, in_ready}, 32'h0);
    check("bp_sb_depth", sb.size(), 2);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    check("bp_drained", sb.size(), 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(1'b1, OR, 32'h1111_0000, 32'h0000_1111, 32'h1111_1111);
    cycle();
    drive(1'b1, XNOR, 32'h0, 32'h0, 32'hFFFF_FFFF);
    cycle();
    clr = 1'b1;
    drive(1'b1, PASS, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
    cycle();
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("clr_out_valid", {31'b0, out_valid}, 32'h0);
    check("clr_rz", rz, 32'h0);
    check("clr_in_ready", {31'b0, in_ready}, 32'h1);
    lat_chk = 1'b1;
    drive(1'b1, AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000);
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Zero and negative results (exercise flags when present).
    drive(1'b1, AND, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0000);
    cycle();
    drive(1'b1, NOT, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // 8-bit instance: XOR A5^FF, visible two cycles after presentation.
    in_valid8 = 1'b1;
    cycle();
    in_valid8 = 1'b0;
    check("w8_not_early", {31'b0, out_valid8}, 32'h0);
    cycle();
    check("w8_out_valid", {31'b0, out_valid8}, 32'h1);
    check("w8_rz", {24'b0, rz8}, 32'h0000_005A);
`ifdef LOGIC_FLAGS_EN
    check("w8_n_flag", {31'b0, n8}, 32'h0);
`endif

    // Random traffic with random backpressure; inputs held until accepted.
    lat_chk  = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!in_valid || last_acc) begin
        logic [2:0]  o;
        logic [31:0] a, b;
        o = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
        drive(1'($urandom_range(0, 1)), o, a, b, model(o, a, b));
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();
    check("final_sb_empty", sb.size(), 0);
    check("final_out_valid", {31'b0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
